// File: rtl/alu_op_scheduler_if.sv
// Bundle of requester, datapath and response signals around the shared ALU scheduler.
// The slave modport is the scheduler; the master modport is everything around it.
interface alu_op_scheduler_if #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16
);
  logic                      REQ0_VALID, REQ0_READY;
  logic [IN_DATA_WIDTH-1:0]  REQ0_A, REQ0_B;
  logic [3:0]                REQ0_FUNC;
  logic                      REQ1_VALID, REQ1_READY;
  logic [IN_DATA_WIDTH-1:0]  REQ1_A, REQ1_B;
  logic [3:0]                REQ1_FUNC;
  logic [IN_DATA_WIDTH-1:0]  ALU_A, ALU_B;
  logic [1:0]                ALU_FUNC;
  logic [3:0]                UNIT_EN;
  logic [OUT_DATA_WIDTH-1:0] UNIT_OUT;
  logic [3:0]                UNIT_FLAGS;
  logic                      RSP_VALID, RSP_READY;
  logic [OUT_DATA_WIDTH-1:0] RSP_DATA;
  logic                      RSP_ID, RSP_ERR;

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUNC,
    input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUNC,
    output REQ0_READY, REQ1_READY,
    output ALU_A, ALU_B, ALU_FUNC, UNIT_EN,
    input  UNIT_OUT, UNIT_FLAGS,
    output RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR,
    input  RSP_READY
  );

  modport master (
    output REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUNC,
    output REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUNC,
    input  REQ0_READY, REQ1_READY,
    input  ALU_A, ALU_B, ALU_FUNC, UNIT_EN,
    output UNIT_OUT, UNIT_FLAGS,
    input  RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR,
    output RSP_READY
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one ALU datapath between two requesters.
// One op in flight: IDLE -> ISSUE -> WAIT -> RESP, response tagged with requester ID.
module alu_op_scheduler #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16
) (
  input logic               CLK,
  input logic               RST,
  alu_op_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [IN_DATA_WIDTH-1:0] a;
    logic [IN_DATA_WIDTH-1:0] b;
    logic [3:0]               func;
  } req_t;

  state_t     state;
  logic       prio;
  logic [1:0] lat_unit;
  logic       lat_id;

  logic gnt_vld, gnt_id;
  req_t req0, req1, sel;

  always_comb begin
    req0    = '{a: bus.REQ0_A, b: bus.REQ0_B, func: bus.REQ0_FUNC};
    req1    = '{a: bus.REQ1_A, b: bus.REQ1_B, func: bus.REQ1_FUNC};
    // prio only breaks ties; a lone requester always wins
    gnt_id  = (bus.REQ0_VALID && bus.REQ1_VALID) ? prio : bus.REQ1_VALID;
    gnt_vld = !RST && (state == IDLE) && (bus.REQ0_VALID || bus.REQ1_VALID);
    sel     = gnt_id ? req1 : req0;
    bus.REQ0_READY = gnt_vld && !gnt_id;
    bus.REQ1_READY = gnt_vld && gnt_id;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      prio          <= 1'b0;
      lat_unit      <= '0;
      lat_id        <= 1'b0;
      bus.ALU_A     <= '0;
      bus.ALU_B     <= '0;
      bus.ALU_FUNC  <= '0;
      bus.UNIT_EN   <= '0;
      bus.RSP_VALID <= 1'b0;
      bus.RSP_DATA  <= '0;
      bus.RSP_ID    <= 1'b0;
      bus.RSP_ERR   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          bus.ALU_A    <= sel.a;
          bus.ALU_B    <= sel.b;
          bus.ALU_FUNC <= sel.func[1:0];
          bus.UNIT_EN  <= 4'b0001 << sel.func[3:2];
          lat_unit     <= sel.func[3:2];
          lat_id       <= gnt_id;
          prio         <= ~gnt_id;
          state        <= ISSUE;
        end
        ISSUE: begin
          bus.UNIT_EN <= '0;
          state       <= WAIT;
        end
        // datapath result registered on the ISSUE edge is on UNIT_OUT now
        WAIT: begin
          bus.RSP_DATA  <= bus.UNIT_OUT[OUT_DATA_WIDTH-1:0];
          bus.RSP_ERR   <= ~bus.UNIT_FLAGS[lat_unit];
          bus.RSP_ID    <= lat_id;
          bus.RSP_VALID <= 1'b1;
          state         <= RESP;
        end
        RESP: if (bus.RSP_READY) begin
          bus.RSP_VALID <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler: vector table plus arbitration, backpressure,
// flag-error and mid-op reset sequences against a simple 1-cycle datapath stand-in.
module tb_alu_op_scheduler;

  logic CLK, RST;
  logic [3:0] flag_kill;
  int n_vec, n_err;

  alu_op_scheduler_if #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(16)) bus ();

  alu_op_scheduler #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Datapath stand-in: arith {add,sub}, logic {and,or,xor,not}, cmp {eq,ltu}, shift {shl,shr}
  function automatic logic [15:0] alu_fn(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    case (fn)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return ~a;
      4'b1000: return {15'b0, a == b};
      4'b1001: return {15'b0, a < b};
      4'b1100: return a << b[3:0];
      4'b1101: return a >> b[3:0];
      default: return 16'h0;
    endcase
  endfunction

  logic [1:0] unit_idx;
  always_comb begin
    unit_idx = 2'd0;
    case (bus.UNIT_EN)
      4'b0010: unit_idx = 2'd1;
      4'b0100: unit_idx = 2'd2;
      4'b1000: unit_idx = 2'd3;
      default: unit_idx = 2'd0;
    endcase
  end

  always @(posedge CLK) begin
    if (RST) begin
      bus.UNIT_OUT   <= 16'h0;
      bus.UNIT_FLAGS <= 4'h0;
    end else if (|bus.UNIT_EN) begin
      bus.UNIT_OUT   <= alu_fn({unit_idx, bus.ALU_FUNC}, bus.ALU_A, bus.ALU_B);
      bus.UNIT_FLAGS <= bus.UNIT_EN & ~flag_kill;
    end else begin
      bus.UNIT_FLAGS <= 4'h0;
    end
  end

  typedef struct {
    logic        rid;
    logic [15:0] a, b;
    logic [3:0]  func;
    logic [3:0]  en;
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic rid, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f);
    if (rid) begin
      bus.REQ1_VALID = v; bus.REQ1_A = a; bus.REQ1_B = b; bus.REQ1_FUNC = f;
    end else begin
      bus.REQ0_VALID = v; bus.REQ0_A = a; bus.REQ0_B = b; bus.REQ0_FUNC = f;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Request at a negedge, wait for the grant; returns just after the accept edge (T).
  task automatic issue_req(input vec_t v, output logic ok);
    logic rdy;
    ok = 1'b0;
    @(negedge CLK);
    set_req(v.rid, 1'b1, v.a, v.b, v.func);
    for (int k = 0; k < 20; k++) begin
      #1;
      rdy = v.rid ? bus.REQ1_READY : bus.REQ0_READY;
      if (rdy) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    chk("grant_seen", {31'b0, ok}, 32'd1);
    if (ok) @(posedge CLK);
    #1 set_req(v.rid, 1'b0, v.a, v.b, v.func);
  endtask

  // Full op; returns at the negedge of cycle T+3 with the response presented.
  task automatic do_op(input vec_t v, input string nm);
    logic ok;
    issue_req(v, ok);
    @(negedge CLK);
    chk({nm, ".unit_en"}, {28'b0, bus.UNIT_EN}, {28'b0, v.en});
    chk({nm, ".alu_a"}, {16'b0, bus.ALU_A}, {16'b0, v.a});
    @(negedge CLK);
    chk({nm, ".en_off_wait"}, {28'b0, bus.UNIT_EN}, 32'd0);
    @(negedge CLK);
    chk({nm, ".rsp_valid"}, {31'b0, bus.RSP_VALID}, 32'd1);
    chk({nm, ".rsp_data"}, {16'b0, bus.RSP_DATA}, {16'b0, v.data});
    chk({nm, ".rsp_id"}, {31'b0, bus.RSP_ID}, {31'b0, v.rid});
    chk({nm, ".rsp_err"}, {31'b0, bus.RSP_ERR}, {31'b0, v.err});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".unit_en"}, {28'b0, bus.UNIT_EN}, 32'd0);
    chk({nm, ".alu"}, {bus.ALU_A, bus.ALU_B[15:2], bus.ALU_FUNC}, 32'd0);
    chk({nm, ".alu_b_lo"}, {30'b0, bus.ALU_B[1:0]}, 32'd0);
    chk({nm, ".rsp"}, {13'b0, bus.RSP_VALID, bus.RSP_ID, bus.RSP_ERR, bus.RSP_DATA}, 32'd0);
  endtask

  initial begin
    logic [15:0] sdata;
    logic ids[3];
    logic [15:0] dats[3];
    int got, seen;
    n_vec = 0; n_err = 0;
    RST = 1'b1; flag_kill = 4'h0;
    bus.RSP_READY = 1'b1;
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);

    //        rid  a        b        func     en       data     err
    vt[0] = '{1'b0, 16'h00FF, 16'h0F0F, 4'b0100, 4'b0010, 16'h000F, 1'b0};
    vt[1] = '{1'b0, 16'h1234, 16'h0001, 4'b0000, 4'b0001, 16'h1235, 1'b0};
    vt[2] = '{1'b1, 16'h0005, 16'h0007, 4'b0001, 4'b0001, 16'hFFFE, 1'b0};
    vt[3] = '{1'b1, 16'hF0F0, 16'h0F0F, 4'b0101, 4'b0010, 16'hFFFF, 1'b0};
    vt[4] = '{1'b0, 16'h0003, 16'h0009, 4'b1001, 4'b0100, 16'h0001, 1'b0};
    vt[5] = '{1'b0, 16'h0001, 16'h0004, 4'b1100, 4'b1000, 16'h0010, 1'b0};
    vt[6] = '{1'b1, 16'h8000, 16'h000F, 4'b1101, 4'b1000, 16'h0001, 1'b0};
    // shift op whose unit flag is suppressed by the datapath stand-in
    vt[7] = '{1'b0, 16'h0100, 16'h0004, 4'b1101, 4'b1000, 16'h0010, 1'b1};

    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk_zero("reset");
    chk("reset.ready", {30'b0, bus.REQ1_READY, bus.REQ0_READY}, 32'd0);

    for (int i = 0; i < 7; i++) do_op(vt[i], $sformatf("vec%0d", i));

    // Both valid after reset: expect grants 0,1,0
    do_reset();
    @(negedge CLK);
    set_req(1'b0, 1'b1, 16'h0002, 16'h0003, 4'b0000);
    set_req(1'b1, 1'b1, 16'h00FF, 16'h0F0F, 4'b0110);
    got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge CLK);
      if (bus.RSP_VALID) begin
        ids[got] = bus.RSP_ID; dats[got] = bus.RSP_DATA; got++;
      end
    end
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);
    chk("arb.count", got, 32'd3);
    if (got == 3) begin
      chk("arb.id0", {31'b0, ids[0]}, 32'd0);
      chk("arb.id1", {31'b0, ids[1]}, 32'd1);
      chk("arb.id2", {31'b0, ids[2]}, 32'd0);
      chk("arb.d0", {16'b0, dats[0]}, 32'h0005);
      chk("arb.d1", {16'b0, dats[1]}, 32'h0FF0);
    end

    // Lone REQ1 wins every time even though PRIO points at 0 after reset
    do_reset();
    for (int i = 0; i < 3; i++) do_op(vt[2 + (i % 2)], $sformatf("r1only%0d", i));

    // Backpressure: response held for 6 cycles of RSP_READY low
    do_reset();
    bus.RSP_READY = 1'b0;
    do_op(vt[0], "bp");
    sdata = bus.RSP_DATA;
    set_req(1'b0, 1'b1, 16'h1111, 16'h2222, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp.hold_valid", {31'b0, bus.RSP_VALID}, 32'd1);
      chk("bp.hold_data", {16'b0, bus.RSP_DATA}, {16'b0, sdata});
      chk("bp.no_grant", {31'b0, bus.REQ0_READY}, 32'd0);
    end
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    chk("bp.valid_drop", {31'b0, bus.RSP_VALID}, 32'd0);
    chk("bp.idle_grant", {31'b0, bus.REQ0_READY}, 32'd1);
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);

    // Unit flag missing at capture -> RSP_ERR with data still returned
    flag_kill = 4'b1000;
    do_op(vt[7], "flagerr");
    flag_kill = 4'h0;

    // Reset during WAIT drops the op and restores PRIO=0
    do_reset();
    begin
      logic ok;
      issue_req(vt[1], ok);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_zero("rstwait");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (bus.RSP_VALID) seen++;
    end
    chk("rstwait.no_rsp", seen, 32'd0);
    set_req(1'b0, 1'b1, 16'h0001, 16'h0001, 4'b0000);
    set_req(1'b1, 1'b1, 16'h0001, 16'h0001, 4'b0000);
    #1;
    chk("rstwait.prio", {30'b0, bus.REQ1_READY, bus.REQ0_READY}, 32'd1);
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares one ALU datapath (arithmetic, logic, compare and shift units) between two requesters.
- Round-robin arbitration; accepts one operation at a time and drives operands, function code and the one-hot unit enable.
- Captures the unit's registered result one cycle after issue and returns it to the granted requester over a valid/ready response channel tagged with the requester ID.

Parameters:
- IN_DATA_WIDTH, 16, operand width of A/B
- OUT_DATA_WIDTH, 16, result width

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset; synchronous, active-high
- REQ0_VALID  in  1  requester 0 has an operation
- REQ0_READY  out  1  requester 0 operation accepted this cycle
- REQ0_A, REQ0_B  in  IN_DATA_WIDTH  requester 0 operands
- REQ0_FUNC  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit function
- REQ1_VALID / REQ1_READY / REQ1_A / REQ1_B / REQ1_FUNC  same as requester 0
- ALU_A, ALU_B  out  IN_DATA_WIDTH  operands to datapath
- ALU_FUNC  out  2  function code to the selected unit
- UNIT_EN  out  4  one-hot enables {shift, cmp, logic, arith}
- UNIT_OUT  in  OUT_DATA_WIDTH  registered result bus from the datapath
- UNIT_FLAGS  in  4  per-unit registered valid flags {shift, cmp, logic, arith}
- RSP_VALID  out  1  response available
- RSP_READY  in  1  consumer accepts response
- RSP_DATA  out  OUT_DATA_WIDTH  captured result
- RSP_ID  out  1  requester the response belongs to
- RSP_ERR  out  1  selected unit flag was low at capture

Behaviour:
- Reset (synchronous, RST=1 at posedge):
  - State goes to IDLE; priority pointer PRIO=0.
  - All outputs are 0: UNIT_EN=0, ALU_A/B/FUNC=0, RSP_*=0, REQx_READY=0.
  - Any in-flight operation is dropped silently.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any REQx_VALID, grant one: the only valid requester, or requester PRIO if both are valid.
  - REQx_READY is combinational, high only in IDLE for the granted requester.
  - On the handshake, latch A, B, FUNC and ID; PRIO <= ~granted ID; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (one cycle):
  - Drive ALU_A/ALU_B/ALU_FUNC from the latched values.
  - UNIT_EN = one-hot decode of FUNC[3:2]; go to WAIT.
  - UNIT_EN is 0 in every other state.
- WAIT (one cycle):
  - Datapath has 1-cycle latency, so UNIT_OUT and UNIT_FLAGS are valid now.
  - Capture RSP_DATA <= UNIT_OUT, RSP_ERR <= ~UNIT_FLAGS[FUNC[3:2]], RSP_ID <= latched ID; go to RESP.
  - If the selected flag is low, RSP_DATA is still captured as-is.
- RESP:
  - RSP_VALID=1; RSP_DATA, RSP_ID and RSP_ERR are held stable until RSP_READY=1.
  - On the handshake, RSP_VALID drops next cycle and the FSM goes to IDLE.
  - No new request is accepted until back in IDLE.
- Latency: request accepted at cycle T, UNIT_EN high at T+1, capture at T+2, RSP_VALID from T+3.
- Peak throughput: 1 op per 4 cycles, with RSP_READY tied high.
- Requester rules:
  - Must hold VALID, A, B and FUNC stable until READY.
  - Dropping VALID before READY withdraws the request and is legal.
- Arbitration is starvation-free: with both requesters continuously valid, grants alternate 0,1,0,1.
- RST asserted in any state overrides everything in that same edge, including a simultaneous request or response handshake.

Test Plan:
- After reset, REQ0 sends A=0x00FF, B=0x0F0F, FUNC=4'b0100 (logic AND), UNIT_OUT model returns 0x000F with flag bit1 -> UNIT_EN=4'b0010 at T+1; RSP_VALID=1, RSP_DATA=0x000F, RSP_ID=0, RSP_ERR=0 at T+3.
- Both REQ0 and REQ1 valid in the same cycle after reset -> REQ0 granted first, REQ1 next; a third op from REQ0 follows (0,1,0 order).
- Only REQ1 valid repeatedly -> REQ1 granted every time despite PRIO; each response has RSP_ID=1.
- RSP_READY held low 5 cycles in RESP -> RSP_VALID/RSP_DATA stable throughout; REQx_READY stays 0; IDLE one cycle after RSP_READY=1.
- FUNC=4'b1101 (shift unit) with the datapath model not asserting UNIT_FLAGS[3] -> UNIT_EN=4'b1000, RSP_ERR=1.
- RST pulsed while in WAIT -> next cycle all outputs 0, state IDLE, no response ever issued for that op; PRIO=0.
